// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ImmSrc encodings,
// the main control bundle and the decode-controller state.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;

    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_SU = 2'b01;
    localparam logic [1:0] IMM_B  = 2'b10;
    localparam logic [1:0] IMM_J  = 2'b11;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

endpackage

// File: rtl/riscv_main_dec.sv
// Main opcode decoder: ImmSrc, control bundle, source-register
// usage per instruction format, and the illegal-opcode flag.
module riscv_main_dec
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_src,
    output ctrl_t      ctrl,
    output logic       rs1_used,
    output logic       rs2_used,
    output logic       illegal
);

    always_comb begin
        imm_src  = IMM_I;
        ctrl     = CTRL_NONE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        illegal  = 1'b0;
        unique case (1'b1)
            (opcode == OP_LOAD): begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                rs1_used       = 1'b1;
            end
            (opcode == OP_IMM): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                rs1_used       = 1'b1;
            end
            (opcode == OP_JALR): begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.alu_src   = 1'b1;
                rs1_used       = 1'b1;
            end
            (opcode == OP_STORE): begin
                imm_src        = IMM_SU;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            // U-type shares the S encoding; instr[4] selects the U layout
            (opcode == OP_LUI || opcode == OP_AUIPC): begin
                imm_src        = IMM_SU;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            (opcode == OP_BRANCH): begin
                imm_src     = IMM_B;
                ctrl.branch = 1'b1;
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
            end
            (opcode == OP_JAL): begin
                imm_src        = IMM_J;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            (opcode == OP_R): begin
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_id_ctrl.sv
// Decode-stage controller: IF/ID handshake, load-use and
// back-pressure stalls, flush, illegal-opcode trap, ID/EX register.
module riscv_id_ctrl
    import riscv_pkg::*;
#(
    parameter int RF_ADDR_W    = 5,
    parameter bit ILLEGAL_HOLD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    output logic                 id_ready,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic [1:0]           imm_src_d,
    output logic                 instr_4_d,
    output logic                 ex_valid,
    output logic [1:0]           ex_imm_src,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_alu_src,
    output logic                 ex_branch,
    output logic                 ex_jump,
    output logic [RF_ADDR_W-1:0] ex_rd,
    output logic [RF_ADDR_W-1:0] ex_rs1,
    output logic [RF_ADDR_W-1:0] ex_rs2,
    output logic                 ex_illegal,
    output logic                 trap
);

    state_t                 state;
    state_t                 state_nx;
    ctrl_t                  ctrl_d;
    ctrl_t                  ex_ctrl;
    logic                   rs1_used;
    logic                   rs2_used;
    logic                   illegal_d;
    logic [RF_ADDR_W-1:0]   rd_d;
    logic [RF_ADDR_W-1:0]   rs1_d;
    logic [RF_ADDR_W-1:0]   rs2_d;
    logic                   hz;
    logic                   adv;
    logic                   take;
    logic                   unused_bits;

    riscv_main_dec u_dec (
        .opcode   (id_instr[6:0]),
        .imm_src  (imm_src_d),
        .ctrl     (ctrl_d),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .illegal  (illegal_d)
    );

    assign instr_4_d   = id_instr[4];
    assign rd_d        = RF_ADDR_W'(id_instr[11:7]);
    assign rs1_d       = RF_ADDR_W'(id_instr[19:15]);
    assign rs2_d       = RF_ADDR_W'(id_instr[24:20]);
    assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

    assign hz = id_valid & ex_valid & ex_ctrl.mem_read
              & (ex_rd != '0)
              & ((rs1_used & (ex_rd == rs1_d))
               | (rs2_used & (ex_rd == rs2_d)));

    assign adv      = !ex_valid | ex_ready;
    assign id_ready = adv & !hz & (state == RUN) & !flush;
    assign take     = id_valid & id_ready;
    assign trap     = (state == TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = RUN;
        else if (take && illegal_d && ILLEGAL_HOLD)
            state_nx = TRAP;
    end

    // A bubble clears mem_read so the same hazard cannot fire twice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_imm_src <= IMM_I;
            ex_ctrl    <= CTRL_NONE;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv && hz) begin
            ex_valid         <= 1'b0;
            ex_ctrl.mem_read <= 1'b0;
        end else if (take) begin
            ex_valid   <= !(illegal_d && !ILLEGAL_HOLD);
            ex_imm_src <= imm_src_d;
            ex_ctrl    <= ctrl_d;
            ex_rd      <= rd_d;
            ex_rs1     <= rs1_d;
            ex_rs2     <= rs2_d;
            ex_illegal <= illegal_d;
        end else if (adv) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_reg_write = ex_ctrl.reg_write;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_alu_src   = ex_ctrl.alu_src;
    assign ex_branch    = ex_ctrl.branch;
    assign ex_jump      = ex_ctrl.jump;

endmodule

// File: tb/tb_riscv_id_ctrl.sv
// Scoreboard bench for riscv_id_ctrl: directed RV32I vectors with
// hand-computed decode bundles, stalls, flush, trap and async reset.
module tb_riscv_id_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic [1:0]  imm_src_d;
    logic        instr_4_d;
    logic        ex_valid;
    logic [1:0]  ex_imm_src;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_alu_src;
    logic        ex_branch;
    logic        ex_jump;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_illegal;
    logic        trap;

    riscv_id_ctrl #(
        .RF_ADDR_W    (5),
        .ILLEGAL_HOLD (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_ready     (id_ready),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .imm_src_d    (imm_src_d),
        .instr_4_d    (instr_4_d),
        .ex_valid     (ex_valid),
        .ex_imm_src   (ex_imm_src),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_alu_src   (ex_alu_src),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .ex_rd        (ex_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_illegal   (ex_illegal),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    // c = {reg_write, mem_read, mem_write, alu_src, branch, jump}
    typedef struct packed {
        logic [1:0] imm;
        logic [5:0] c;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] imm, input logic [5:0] c,
                                input int rd, input int rs1, input int rs2,
                                input logic ill);
        exp_t e;
        e.imm = imm;
        e.c   = c;
        e.rd  = 5'(rd);
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.ill = ill;
        return e;
    endfunction

    // EX consumes the ID/EX register on every cycle with valid & ready
    always @(negedge clk) begin
        exp_t act;
        #2;
        if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
            act = {ex_imm_src, ex_reg_write, ex_mem_read, ex_mem_write,
                   ex_alu_src, ex_branch, ex_jump, ex_rd, ex_rs1,
                   ex_rs2, ex_illegal};
            if (q.size() == 0) check("sb_unexpected", 32'(q.size()), 1);
            else check("sb_bundle", 32'(act), 32'(q.pop_front()));
        end
    end

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [31:0] ins, input exp_t e,
                        input logic i4, output int stalls,
                        output logic [7:0] hist);
        stalls   = 0;
        hist     = '0;
        id_valid = 1'b1;
        id_instr = ins;
        #1;
        check("imm_src_d", 32'(imm_src_d), 32'(e.imm));
        check("instr_4_d", 32'(instr_4_d), 32'(i4));
        while (1) begin
            hist = {hist[6:0], ex_valid};
            if (id_ready === 1'b1) begin
                q.push_back(e);
                @(posedge clk);
                break;
            end
            stalls++;
            if (stalls > 20) begin
                check("accept_timeout", 32'(stalls), 0);
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        id_valid = 1'b0;
    endtask

    localparam logic [31:0] ADDI  = 32'h00A00093;
    localparam logic [31:0] SW    = 32'h0020A423;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD   = 32'h00228333;
    localparam logic [31:0] LW0   = 32'h0000A003;
    localparam logic [31:0] ADD0  = 32'h00200333;
    localparam logic [31:0] ILL   = 32'h0000007F;

    logic [31:0] sw_ins [8] = '{
        32'h00A00093, 32'h0020A423, 32'h123451B7, 32'h00000217,
        32'h00208463, 32'h010000EF, 32'h00008067, 32'h00228333
    };
    logic        sw_i4 [8] = '{1, 0, 1, 1, 0, 0, 0, 1};
    exp_t        sw_exp [8];

    exp_t        e_addi, e_sw, e_lw5, e_add, e_lw0, e_add0, e_ill;
    int          st;
    logic [7:0]  h;

    initial begin
        sw_exp[0] = mk(2'b00, 6'b100100, 1, 0, 10, 0);
        sw_exp[1] = mk(2'b01, 6'b001100, 8, 1, 2, 0);
        sw_exp[2] = mk(2'b01, 6'b100100, 3, 8, 3, 0);
        sw_exp[3] = mk(2'b01, 6'b100100, 4, 0, 0, 0);
        sw_exp[4] = mk(2'b10, 6'b000010, 8, 1, 2, 0);
        sw_exp[5] = mk(2'b11, 6'b100001, 1, 0, 16, 0);
        sw_exp[6] = mk(2'b00, 6'b100101, 0, 1, 0, 0);
        sw_exp[7] = mk(2'b00, 6'b100000, 6, 5, 2, 0);
        e_addi    = sw_exp[0];
        e_sw      = sw_exp[1];
        e_add     = sw_exp[7];
        e_lw5     = mk(2'b00, 6'b110100, 5, 1, 0, 0);
        e_lw0     = mk(2'b00, 6'b110100, 0, 1, 0, 0);
        e_add0    = mk(2'b00, 6'b100000, 6, 0, 2, 0);
        e_ill     = mk(2'b00, 6'b000000, 0, 0, 0, 1);

        rst_n    = 1'b0;
        id_valid = 1'b0;
        id_instr = '0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        #12;
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write,
                               ex_alu_src, ex_branch, ex_jump,
                               ex_illegal, ex_imm_src}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // decode sweep, back-to-back
        for (int i = 0; i < 8; i++) begin
            send(sw_ins[i], sw_exp[i], sw_i4[i], st, h);
            check("sweep_stall", 32'(st), 0);
        end

        // load-use: exactly one bubble
        send(LW5, e_lw5, 1'b0, st, h);
        send(ADD, e_add, 1'b1, st, h);
        check("lu_stall", 32'(st), 1);
        check("lu_hist", 32'(h[1:0]), 32'b10);
        #1;
        check("lu_valid_after", 32'(ex_valid), 1);
        @(negedge clk);

        // load into x0 never stalls
        send(LW0, e_lw0, 1'b0, st, h);
        send(ADD0, e_add0, 1'b1, st, h);
        check("x0_stall", 32'(st), 0);

        // back-pressure for three cycles
        send(ADDI, e_addi, 1'b1, st, h);
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_instr = SW;
        repeat (3) begin
            #1;
            check("bp_ready", 32'(id_ready), 0);
            check("bp_valid", 32'(ex_valid), 1);
            check("bp_rd", 32'(ex_rd), 1);
            @(negedge clk);
        end
        ex_ready = 1'b1;
        send(SW, e_sw, 1'b0, st, h);
        check("bp_resume_stall", 32'(st), 0);

        // flush coincident with a load-use hazard
        send(LW5, e_lw5, 1'b0, st, h);
        flush    = 1'b1;
        id_valid = 1'b1;
        id_instr = ADD;
        #1;
        check("fl_ready", 32'(id_ready), 0);
        @(negedge clk);
        flush    = 1'b0;
        id_valid = 1'b0;
        #1;
        check("fl_valid", 32'(ex_valid), 0);
        check("fl_no_capture", 32'(ex_rd), 5);
        @(negedge clk);
        send(ADD, e_add, 1'b1, st, h);
        check("fl_next_stall", 32'(st), 0);

        // illegal opcode enters TRAP until flush
        send(ILL, e_ill, 1'b1, st, h);
        id_valid = 1'b1;
        id_instr = ADDI;
        #1;
        check("ill_flag", 32'(ex_illegal), 1);
        repeat (10) begin
            check("trap_ready", 32'(id_ready), 0);
            check("trap_hi", 32'(trap), 1);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        id_valid = 1'b0;
        #1;
        check("trap_cleared", 32'(trap), 0);
        check("trap_ready_back", 32'(id_ready), 1);
        @(negedge clk);

        // asynchronous reset while in TRAP
        send(ILL, e_ill, 1'b1, st, h);
        #1;
        check("pre_rst_valid", 32'(ex_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid), 0);
        check("arst_trap", 32'(trap), 0);
        check("arst_ill", 32'(ex_illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(ADDI, e_addi, 1'b1, st, h);
        check("post_rst_stall", 32'(st), 0);

        @(negedge clk);
        #3;
        check("sb_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/riscv_id_ctrl.md
Name: riscv_id_ctrl

Overview:
Decode-stage controller for the pipelined RV32I core. It accepts instructions from the IF/ID register over a valid/ready handshake and decodes the opcode into ImmSrc/instr_4 for the immediate extender and into the main control bundle. It owns the ID/EX control register and sequences stalls: load-use bubbles, downstream back-pressure, flush and illegal-instruction hold.

Parameters:
RF_ADDR_W, 5, register-file index width
ILLEGAL_HOLD, 1, 1 = enter TRAP on an illegal opcode; 0 = drop it as a bubble

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds an instruction
id_instr  in  32  instruction in IF/ID
id_ready  out  1  decode accepts id_instr this cycle
flush  in  1  branch/jump redirect; kills ID and EX contents
ex_ready  in  1  EX stage accepts the ID/EX register
imm_src_d  out  2  combinational ImmSrc to the immediate extender in ID
instr_4_d  out  1  combinational id_instr[4] to the immediate extender in ID
ex_valid  out  1  ID/EX register holds a live instruction
ex_imm_src  out  2  registered ImmSrc
ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump  out  1 each  registered controls
ex_rd, ex_rs1, ex_rs2  out  RF_ADDR_W each  registered register indices
ex_illegal  out  1  registered illegal-opcode flag
trap  out  1  high while in TRAP

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: all ex_* outputs are 0, trap is 0, state is RUN.
- Opcode decode is combinational. imm_src_d / ctrl:
  - 0000011 load: 00; reg_write, mem_read, alu_src.
  - 0010011 op-imm: 00; reg_write, alu_src.
  - 1100111 jalr: 00; reg_write, jump, alu_src.
  - 0100011 store: 01; mem_write, alu_src.
  - 0110111 lui and 0010111 auipc: 01 (instr_4 = 1); reg_write, alu_src.
  - 1100011 branch: 10; branch.
  - 1101111 jal: 11; reg_write, jump.
  - 0110011 R-type: 00; reg_write.
  - Anything else is illegal: all ctrl 0, imm_src 00.
- instr_4_d = id_instr[4] always.
- rs1 and rs2 are flagged "used" per format:
  - R, S, B use both.
  - I uses rs1 only.
  - U and J use neither.
- Load-use hazard: hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((rs1 used & ex_rd == rs1) | (rs2 used & ex_rd == rs2)).
- Advance condition: adv = !ex_valid | ex_ready.
- id_ready = adv & !hz & (state == RUN) & !flush.
- ID/EX update, priority order:
  1. flush: ex_valid ← 0 next edge, state ← RUN.
  2. adv & hz: bubble loaded; ex_valid ← 0, ex_mem_read ← 0, so the hazard clears the next cycle (exactly 1 bubble).
  3. adv & id_valid & id_ready: capture decode; ex_valid ← 1.
  4. adv otherwise: ex_valid ← 0.
  5. !adv: hold every ex_* field unchanged (HOLD behaviour, no separate state).
- Latency: 1 cycle from accept to ex_valid.
- Illegal handling:
  - ILLEGAL_HOLD = 1: an accepted illegal instruction is captured with ex_illegal = 1. Next state is TRAP, trap = 1, id_ready = 0 until flush. Only flush (or reset) leaves TRAP.
  - ILLEGAL_HOLD = 0: an illegal instruction is accepted but loaded as a bubble.
- Simultaneous events:
  - flush in the same cycle as hz or an illegal instruction: flush wins and nothing is captured.
  - ex_ready low together with hz: hold; the bubble is inserted when adv returns.
- Reset mid-stall or mid-TRAP returns to RUN with ex_valid = 0 immediately (asynchronous).

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_R).
  - ImmSrc encodings IMM_I = 00, IMM_SU = 01, IMM_B = 10, IMM_J = 11.
  - Control-bundle struct and state enum {RUN, TRAP}.
- One sub-module, riscv_main_dec: purely combinational opcode → imm_src, controls, rs-used flags, illegal. riscv_id_ctrl holds the hazard logic, FSM and ID/EX register.

Test Plan:
- Decode sweep: each legal opcode with ex_ready = 1 → imm_src_d and the ex_* bundle match the table one cycle later. Example: 0x00A00093 (addi x1,x0,10) → imm_src 00, reg_write = 1, alu_src = 1, ex_rd = 1.
- Load-use: lw x5,0(x1) then add x6,x5,x2 → id_ready = 0 for exactly 1 cycle; ex_valid sequence 1,0,1. Same pair with rd = x0 → no bubble.
- Back-pressure: ex_ready = 0 for 3 cycles with id_valid = 1 → ex_* stable, id_ready = 0 throughout; resumes with no instruction lost or duplicated.
- Flush: flush = 1 coincident with a hazard → next cycle ex_valid = 0, nothing captured; the following instruction is accepted normally.
- Illegal: opcode 0x7F with ILLEGAL_HOLD = 1 → ex_illegal = 1, trap = 1, id_ready stays 0 for 10 cycles; flush → trap = 0 the next cycle.
- Reset: assert rst_n low mid-TRAP and asynchronously between edges → ex_valid, trap and all controls 0 without waiting for clk.
